aes_top: RTL and testbench

//  Iterative AES-128 encryption core (FIPS-197, encrypt only): one round per clock, on-the-fly key expansion.
//  Top of the AES datapath: accepts a 128-bit plaintext and key, returns ciphertext with a one-cycle valid strobe.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_sbox.sv | 33 +++
 rtl/aes_top.sv | 132 +++++++++++++
 tb/tb_aes_top.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {IDLE, RUN} fsm_e;

  // Round constant for the key word derived in round r (1..10).
  function automatic byte_t rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t mixcolumn(input word_t w);
    byte_t b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  byte_t lut_out;
  assign lut_out = SboxTable[2047 - 8 * int'(data_i) -: 8];
  assign data_o  = lut_out;

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encrypt core, one round per clock with on-the-fly key expansion.
// Define AES_COMPLEMENT_OUT_EN for registered complementary (dual-rail) outputs.
module aes_top
  import aes_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
`ifdef AES_COMPLEMENT_OUT_EN
  ,
  output logic         AES_data_out_complementary_valid,
  output logic [127:0] AES_data_out_complementary
`endif
);

  localparam logic [3:0] LastRound = 4'(NR);

  fsm_e       fsm_q, fsm_d;
  logic [3:0] round_q, round_d;
  block_t     state_q, state_d, rkey_q, rkey_d, data_out_q, data_out_d;
  logic       valid_q, valid_d;

  block_t sub_bytes, shift_rows, mix_cols, next_key, round_out;
  word_t  sub_word, key_tmp;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .data_i(state_q[127-8*i -: 8]),
      .data_o(sub_bytes[127-8*i -: 8])
    );
  end

  // SubWord on the unrotated last key word; rotating afterwards is equivalent.
  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .data_i(rkey_q[31-8*i -: 8]),
      .data_o(sub_word[31-8*i -: 8])
    );
  end

  assign key_tmp = {sub_word[23:0], sub_word[31:24]} ^ {rcon(round_q), 24'h0};
  assign next_key[127:96] = rkey_q[127:96] ^ key_tmp;
  assign next_key[95:64]  = rkey_q[95:64] ^ next_key[127:96];
  assign next_key[63:32]  = rkey_q[63:32] ^ next_key[95:64];
  assign next_key[31:0]   = rkey_q[31:0] ^ next_key[63:32];

  // Byte (r,c) lives at index r+4c; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shift_rows[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
    end
    assign mix_cols[127-32*c -: 32] = mixcolumn(shift_rows[127-32*c -: 32]);
  end

  assign round_out = ((round_q == LastRound) ? shift_rows : mix_cols) ^ next_key;

  always_comb begin
    fsm_d      = fsm_q;
    round_d    = round_q;
    state_d    = state_q;
    rkey_d     = rkey_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (AES_en) begin
          state_d = AES_data_in ^ AES_key_in;
          rkey_d  = AES_key_in;
          round_d = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_out;
        rkey_d  = next_key;
        round_d = round_q + 4'd1;
        if (round_q == LastRound) begin
          data_out_d = round_out;
          valid_d    = 1'b1;
          round_d    = 4'd0;
          fsm_d      = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      fsm_q      <= IDLE;
      round_q    <= 4'd0;
      state_q    <= '0;
      rkey_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      round_q    <= round_d;
      state_q    <= state_d;
      rkey_q     <= rkey_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign AES_data_out       = data_out_q;
  assign AES_data_out_valid = valid_q;

`ifdef AES_COMPLEMENT_OUT_EN
  logic [127:0] data_out_n_q;
  logic         valid_c_q;

  // Separate rail registered from the same next-state; resets to the complement of zero.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      data_out_n_q <= '1;
      valid_c_q    <= 1'b0;
    end else begin
      data_out_n_q <= ~data_out_d;
      valid_c_q    <= valid_d;
    end
  end

  assign AES_data_out_complementary       = data_out_n_q;
  assign AES_data_out_complementary_valid = valid_c_q;
`endif

endmodule

// File: tb/tb_aes_top.sv
// Scoreboard bench for aes_top: known-answer vectors, latency, back-to-back, abort.
module tb_aes_top;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic [127:0] data_out;
  logic         data_out_valid;
`ifdef AES_COMPLEMENT_OUT_EN
  logic [127:0] data_out_c;
  logic         data_out_c_valid;
`endif

  aes_top u_dut (
    .AES_clk           (clk),
    .AES_rst           (rst),
    .AES_en            (en),
    .AES_data_in       (data_in),
    .AES_key_in        (key_in),
    .AES_data_out      (data_out),
    .AES_data_out_valid(data_out_valid)
`ifdef AES_COMPLEMENT_OUT_EN
    ,
    .AES_data_out_complementary_valid(data_out_c_valid),
    .AES_data_out_complementary      (data_out_c)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] ct;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Pt2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Ct0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid strobe must match the oldest expected block and its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (data_out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid cyc=%0d data_out=%h", cyc, data_out);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (data_out !== e.ct) begin
          errors++;
          $display("FAIL ciphertext got=%h exp=%h", data_out, e.ct);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, e.due);
        end
`ifdef AES_COMPLEMENT_OUT_EN
        checks++;
        if (data_out_c !== ~e.ct || data_out_c_valid !== 1'b1) begin
          errors++;
          $display("FAIL complement got=%h/%b exp=%h/1", data_out_c, data_out_c_valid, ~e.ct);
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One-cycle enable pulse; the edge after the driving negedge is the sampling edge.
  task automatic start(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct);
    @(negedge clk);
    key_in  = key;
    data_in = pt;
    en      = 1'b1;
    @(negedge clk);
    sb_q.push_back('{ct: ct, due: cyc + 10});
    en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d exp=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, '0);
    check("reset_valid", {127'b0, data_out_valid}, '0);
    rst = 1'b0;

    start(Key1, Pt1, Ct1);
    drain("vec1");
    start(Key2, Pt2, Ct2);
    drain("vec2");
    repeat (3) @(negedge clk);
    check("hold_data_out", data_out, Ct2);

    // Enable held across 51 edges: starts at E0, E11, E22, E33, E44.
    @(negedge clk);
    key_in  = '0;
    data_in = '0;
    en      = 1'b1;
    @(negedge clk);
    k = cyc;
    for (int i = 0; i < 5; i++) sb_q.push_back('{ct: Ct0, due: k + 10 + 11 * i});
    repeat (50) @(negedge clk);
    en = 1'b0;
    drain("zero_burst");

    // Inputs churn while the block is running.
    start(Key2, Pt2, Ct2);
    for (int i = 0; i < 12; i++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      key_in  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    drain("input_churn");

    // Abort mid-run: no pending entry, so any late valid is flagged by the monitor.
    start(Key1, Pt1, Ct1);
    void'(sb_q.pop_back());
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_data_out", data_out, '0);
    check("abort_valid", {127'b0, data_out_valid}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_result", data_out, '0);

    start(Key1, Pt1, Ct1);
    drain("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
